// File: rtl/mem_sync_pkg.sv
// Shared types and helpers for the synchronous scratch memory (mem_sync_ctrl).
package mem_sync_pkg;

    localparam int BYTE = 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int lane_count(input int dw);
        return dw / BYTE;
    endfunction

    function automatic logic even_parity(input logic [BYTE-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mem_sync_array.sv
// Storage array with byte-enable write and registered read-before-write port.
// Optional per-byte even parity when MEM_SYNC_PARITY_EN is defined.
module mem_sync_array
    import mem_sync_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic                     i_rd_zero,
    input  logic [AW-1:0]            i_addr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [lane_count(DW)-1:0] i_wmask,
`ifdef MEM_SYNC_PARITY_EN
    output logic                     o_par_err,
`endif
    output logic [DW-1:0]            o_rdata
);

    localparam int NB = lane_count(DW);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

`ifdef MEM_SYNC_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_par_mis;
    logic          r_par_err;

    // Recompute parity of the addressed word and compare with stored bits.
    always_comb begin
        w_par_mis = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            w_par_mis[i] = even_parity(r_mem[i_addr][i*BYTE +: BYTE]) ^ r_par[i_addr][i];
        end
    end

    // Parity flag travels with the read data; out-of-range reads never flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= i_re && !i_rd_zero && (|w_par_mis);
        end
    end

    // Parity bits follow the byte enables of the data write.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NB; i++) begin
            if (i_we && i_wmask[i]) begin
                r_par[i_addr][i] <= even_parity(i_wdata[i*BYTE +: BYTE]);
            end
        end
    end

    assign o_par_err = r_par_err;
`endif

    // Byte-enabled data write.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NB; i++) begin
            if (i_we && i_wmask[i]) begin
                r_mem[i_addr][i*BYTE +: BYTE] <= i_wdata[i*BYTE +: BYTE];
            end
        end
    end

    // Registered read; old contents win on a same-cycle write to the same word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= {DW{1'b0}};
        end else if (i_re) begin
            r_rdata <= i_rd_zero ? {DW{1'b0}} : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_sync_ctrl.sv
// Clocked scratch memory: clear-after-reset sequencer, range check and error pulse.
// Build option MEM_SYNC_PARITY_EN adds per-byte parity and the ParityErr output.
module mem_sync_ctrl
    import mem_sync_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      MemWr,
    input  logic                      MemRd,
    input  logic [AW-1:0]             Addr,
    input  logic [DW-1:0]             WrData,
    input  logic [lane_count(DW)-1:0] WrMask,
    output logic [DW-1:0]             RdData,
    output logic                      RdValid,
    output logic                      Ready,
`ifdef MEM_SYNC_PARITY_EN
    output logic                      ParityErr,
`endif
    output logic                      AccessErr
);

    localparam int            NB      = lane_count(DW);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

    state_e          r_state, w_state_nxt;
    logic [AW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_ready, r_rd_valid, r_access_err;
    logic            w_in_range;
    logic            w_we, w_re, w_rd_zero, w_err;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic [NB-1:0]   w_wmask;

    assign w_in_range = ({1'b0, Addr} < DEPTH_W);

    // State, clear counter and registered status outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= ST_INIT;
            r_cnt        <= {AW{1'b0}};
            r_ready      <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_access_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ready      <= (w_state_nxt == ST_RUN);
            r_rd_valid   <= w_re;
            r_access_err <= w_err;
        end
    end

    // Next state and array port steering: clear sweep in INIT, user access in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_rd_zero   = 1'b0;
        w_err       = 1'b0;
        w_addr      = Addr;
        w_wdata     = WrData;
        w_wmask     = WrMask;
        case (r_state)
            ST_INIT: begin
                w_we    = 1'b1;
                w_addr  = r_cnt;
                w_wdata = {DW{1'b0}};
                w_wmask = {NB{1'b1}};
                w_err   = MemWr || MemRd;
                if (r_cnt == LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = {AW{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                w_we      = MemWr && w_in_range;
                w_re      = MemRd;
                w_rd_zero = !w_in_range;
                w_err     = (MemWr || MemRd) && !w_in_range;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = {AW{1'b0}};
            end
        endcase
    end

    mem_sync_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_we      (w_we && !Rst),
        .i_re      (w_re),
        .i_rd_zero (w_rd_zero),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .i_wmask   (w_wmask),
`ifdef MEM_SYNC_PARITY_EN
        .o_par_err (ParityErr),
`endif
        .o_rdata   (RdData)
    );

    assign RdValid   = r_rd_valid;
    assign Ready     = r_ready;
    assign AccessErr = r_access_err;

endmodule
